usb_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single 8-bit TX stream of the FTDI 245-FIFO bridge (`TX_DEXP=0`) among `NCH` independent requesters, all in the `tx_clk` domain. Each requester posts a length descriptor and then streams exactly that many bytes. The arbiter frames each packet as a 2-byte header (channel marker, length) followed by the payload, so the host can demultiplex the channels. It sits directly in front of the bridge's `tx_valid`/`tx_ready`/`tx_data` port.

---
 rtl/usb_tx_pkg.sv | 21 ++
 rtl/usb_tx_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 31 +++
 rtl/usb_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_usb_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and helpers for the tx_clk-domain USB TX path.
// Header byte layout: {MARK nibble, channel nibble}.
package usb_tx_pkg;

   localparam int         CH_W         = 4;
   localparam int         BYTE_W       = 8;
   localparam logic [3:0] MARK_DEFAULT = 4'hA;

   typedef enum logic [1:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA
   } tx_state_e;

   function automatic logic [BYTE_W-1:0] hdr_byte(input logic [3:0] mark,
                                                  input logic [CH_W-1:0] ch);
      return {mark, ch};
   endfunction

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// Requester/bridge bundle around the TX arbiter; master is the arbiter side.
interface usb_tx_arbiter_if
   import usb_tx_pkg::*;
#(
   parameter int NCH = 4
);

   logic [NCH-1:0]        req_valid;
   logic [NCH-1:0]        req_ready;
   logic [BYTE_W*NCH-1:0] req_len;
   logic [NCH-1:0]        in_valid;
   logic [NCH-1:0]        in_ready;
   logic [BYTE_W*NCH-1:0] in_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [BYTE_W-1:0]     tx_data;

   modport master (
      input  req_valid, req_len, in_valid, in_data, tx_ready,
      output req_ready, in_ready, tx_valid, tx_data
   );

   modport slave (
      output req_valid, req_len, in_valid, in_data, tx_ready,
      input  req_ready, in_ready, tx_valid, tx_data
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request above last_i, wrapping.
// Shared with the RX-side dispatcher.
module rr_pick
   import usb_tx_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [CH_W-1:0] last_i,
   output logic [CH_W-1:0] grant_o,
   output logic            any_o
);

   int idx;

   // Scan from the far end back toward last_i+1 so the final hit wins.
   always_comb begin
      grant_o = '0;
      any_o   = 1'b0;
      idx     = 0;
      for (int k = NCH; k >= 1; k--) begin
         idx = int'(last_i) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (req_i[idx]) begin
            grant_o = CH_W'(idx);
            any_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-level round-robin arbiter framing NCH byte streams onto the single
// FTDI 245-FIFO TX port as {MARK,ch}, length-1, payload.
module usb_tx_arbiter
   import usb_tx_pkg::*;
#(
   parameter int         NCH  = 4,
   parameter logic [3:0] MARK = MARK_DEFAULT
) (
   input  logic             tx_clk,
   input  logic             rstn_async,
   usb_tx_arbiter_if.master bus,
   output logic             busy,
   output logic [CH_W-1:0]  cur_ch
);

   logic [1:0]        rst_sync_q;
   logic              rst_n;
   tx_state_e         state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   last_q, last_d;
   logic [BYTE_W-1:0] cnt_q, cnt_d;
   logic              tx_valid_q, tx_valid_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic [CH_W-1:0]   gnt;
   logic              any_req;
   logic              slot;
   logic              sel_valid;
   logic [BYTE_W-1:0] sel_data;
   logic [BYTE_W-1:0] sel_len;

   // Assertion takes effect at once; release is retimed through two flops.
   always_ff @(posedge tx_clk or negedge rstn_async) begin
      if (!rstn_async) rst_sync_q <= 2'b00;
      else             rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   rr_pick #(.NCH(NCH)) u_pick (
      .req_i   (bus.req_valid),
      .last_i  (last_q),
      .grant_o (gnt),
      .any_o   (any_req)
   );

   assign slot = ~tx_valid_q | bus.tx_ready;

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      sel_len   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_q == CH_W'(i)) begin
            sel_valid = bus.in_valid[i];
            sel_data  = bus.in_data[BYTE_W*i +: BYTE_W];
         end
         if (gnt == CH_W'(i)) sel_len = bus.req_len[BYTE_W*i +: BYTE_W];
      end
   end

   // Handshakes are combinational so a descriptor or byte moves in one cycle.
   always_comb begin
      bus.req_ready = '0;
      bus.in_ready  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rst_n && (state_q == IDLE) && any_req && (gnt == CH_W'(i)))
            bus.req_ready[i] = 1'b1;
         if ((state_q == DATA) && slot && (ch_q == CH_W'(i)))
            bus.in_ready[i] = 1'b1;
      end
   end

   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         last_q     <= CH_W'(NCH - 1);
         cnt_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      tx_valid_d = tx_valid_q & ~bus.tx_ready;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               ch_d    = gnt;
               last_d  = gnt;
               cnt_d   = sel_len;
               state_d = HDR0;
            end
         end
         HDR0: begin
            if (slot) begin
               tx_valid_d = 1'b1;
               tx_data_d  = hdr_byte(MARK, ch_q);
               state_d    = HDR1;
            end
         end
         HDR1: begin
            if (slot) begin
               tx_valid_d = 1'b1;
               tx_data_d  = cnt_q;
               state_d    = DATA;
            end
         end
         DATA: begin
            // cnt counts remaining bytes minus one, so zero marks the last byte.
            if (slot && sel_valid) begin
               tx_valid_d = 1'b1;
               tx_data_d  = sel_data;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign busy         = (state_q != IDLE);
   assign cur_ch       = ch_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Randomised scoreboard bench for usb_tx_arbiter: packet plans feed a
// round-robin reference model; a negedge monitor checks the TX stream.
module tb_usb_tx_arbiter;

   localparam int         NCH = 4;
   localparam logic [3:0] MK  = 4'hA;

   logic       tx_clk     = 1'b0;
   logic       rstn_async = 1'b0;
   logic       busy;
   logic [3:0] cur_ch;

   usb_tx_arbiter_if #(.NCH(NCH)) bus ();

   usb_tx_arbiter #(.NCH(NCH), .MARK(MK)) dut (
      .tx_clk     (tx_clk),
      .rstn_async (rstn_async),
      .bus        (bus),
      .busy       (busy),
      .cur_ch     (cur_ch)
   );

   always #5 tx_clk = ~tx_clk;

   typedef struct {
      logic [7:0] b;
      bit         hdr;
   } exp_t;

   exp_t       exp_q[$];
   int         acc_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   bit         mon_en    = 1'b0;
   bit         exact_lat = 1'b0;
   bit         abort     = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_d     = '0;

   int         rem_len[NCH][$];
   logic [7:0] pay[NCH][$];
   bit         streaming[NCH];
   int         sent[NCH];
   int         gap_pct = 0;
   int         rdy_pct = 100;
   int         bp_arm  = 0;
   int         bp_cnt  = 0;
   int         m_last  = NCH - 1;

   initial forever begin
      @(posedge tx_clk);
      cyc++;
   end

   // Monitor: pops the scoreboard on every accepted output byte.
   initial forever begin
      exp_t e;
      int   a;
      @(negedge tx_clk);
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.req_ready != '0) begin
            tests++;
            if (!$onehot(bus.req_ready)) begin
               fails++;
               $display("FAIL req_ready_onehot: got %b required one-hot", bus.req_ready);
            end
            acc_q.push_back(cyc);
         end
         if (prev_stall) begin
            tests++;
            if (!(bus.tx_valid === 1'b1 && bus.tx_data === prev_d)) begin
               fails++;
               $display("FAIL tx_hold: got v=%b d=%02h required v=1 d=%02h",
                        bus.tx_valid, bus.tx_data, prev_d);
            end
         end
         if (bus.tx_valid && !bus.tx_ready) begin
            tests++;
            if (bus.in_ready !== '0) begin
               fails++;
               $display("FAIL in_ready_stall: got %b required 0", bus.in_ready);
            end
         end
         if (bus.tx_valid && bus.tx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL tx_extra: got byte %02h required no byte", bus.tx_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.tx_data !== e.b) begin
                  fails++;
                  $display("FAIL tx_byte: got %02h required %02h", bus.tx_data, e.b);
               end
               if (e.hdr) begin
                  tests++;
                  if (acc_q.size() == 0) begin
                     fails++;
                     $display("FAIL hdr_accept: got header %02h required a prior req_ready", e.b);
                  end else begin
                     a = acc_q.pop_front();
                     if (exact_lat ? (cyc - a != 2) : (cyc - a < 2)) begin
                        fails++;
                        $display("FAIL hdr_latency: got %0d cycles required %s2",
                                 cyc - a, exact_lat ? "" : ">=");
                     end
                  end
               end
            end
         end
         prev_stall = bus.tx_valid & ~bus.tx_ready;
         prev_d     = bus.tx_data;
      end
   end

   // One requester-side cycle: observe handshakes, then drive every channel.
   task automatic step();
      logic [NCH-1:0]   rr, ir, rv, iv, nrv, niv;
      logic [8*NCH-1:0] nrl, nid;
      bit               deep;
      @(negedge tx_clk);
      rr = bus.req_ready;
      ir = bus.in_ready;
      rv = bus.req_valid;
      iv = bus.in_valid;
      @(posedge tx_clk);
      #1;
      deep = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (ir[c]) begin
            tests++;
            if (!streaming[c]) begin
               fails++;
               $display("FAIL in_ready_iso: ch%0d got 1 required 0", c);
            end
         end
         if (rv[c] && rr[c]) begin
            streaming[c] = 1'b1;
            sent[c]      = 0;
         end else if (iv[c] && ir[c] && streaming[c]) begin
            void'(pay[c].pop_front());
            sent[c]++;
            if (sent[c] == rem_len[c][0]) begin
               void'(rem_len[c].pop_front());
               streaming[c] = 1'b0;
            end
         end
         if (streaming[c] && sent[c] >= 3) deep = 1'b1;
      end
      nrv = '0;
      niv = '0;
      for (int c = 0; c < NCH; c++) begin
         nrl[8*c +: 8] = 8'($urandom);
         nid[8*c +: 8] = 8'($urandom);
         if (streaming[c]) begin
            niv[c]        = (int'($urandom_range(99, 0)) >= gap_pct);
            nid[8*c +: 8] = pay[c][0];
         end else begin
            niv[c] = 1'($urandom);
            if (rem_len[c].size() > 0) begin
               nrv[c]        = 1'b1;
               nrl[8*c +: 8] = 8'(rem_len[c][0] - 1);
            end
         end
      end
      bus.req_valid = nrv;
      bus.req_len   = nrl;
      bus.in_valid  = niv;
      bus.in_data   = nid;
      if (bp_cnt > 0) begin
         bus.tx_ready = 1'b0;
         bp_cnt--;
      end else if (bp_arm != 0 && deep) begin
         bus.tx_ready = 1'b0;
         bp_cnt       = 4;
         bp_arm       = 0;
      end else begin
         bus.tx_ready = (int'($urandom_range(99, 0)) < rdy_pct);
      end
   endtask

   // Plans packets per channel and pushes the expected framed stream,
   // ordered by round-robin over channels that still have packets queued.
   task automatic load(input logic [NCH-1:0] mask, input int pk_min, input int pk_max,
                       input int len_min, input int len_max);
      int         mlen[NCH][$];
      logic [7:0] mpay[NCH][$];
      int         n, len, tot, c;
      logic [7:0] d;
      tot = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (mask[ch]) begin
            n = int'($urandom_range(pk_max, pk_min));
            for (int p = 0; p < n; p++) begin
               len = int'($urandom_range(len_max, len_min));
               rem_len[ch].push_back(len);
               mlen[ch].push_back(len);
               tot++;
               for (int b = 0; b < len; b++) begin
                  d = 8'($urandom);
                  pay[ch].push_back(d);
                  mpay[ch].push_back(d);
               end
            end
         end
      end
      while (tot > 0) begin
         for (int k = 1; k <= NCH; k++) begin
            c = (m_last + k) % NCH;
            if (mlen[c].size() > 0) begin
               len = mlen[c].pop_front();
               exp_q.push_back('{b: {MK, 4'(c)}, hdr: 1'b1});
               exp_q.push_back('{b: 8'(len - 1), hdr: 1'b0});
               for (int b = 0; b < len; b++) exp_q.push_back('{b: mpay[c].pop_front(), hdr: 1'b0});
               m_last = c;
               tot--;
               break;
            end
         end
      end
   endtask

   function automatic bit pending();
      for (int c = 0; c < NCH; c++) if (rem_len[c].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic phase(input logic [NCH-1:0] mask, input int pk_min, input int pk_max,
                        input int len_min, input int len_max, input int gp, input int rp,
                        input int bp);
      int guard;
      if (abort) return;
      gap_pct   = gp;
      rdy_pct   = rp;
      bp_arm    = bp;
      exact_lat = (rp == 100 && bp == 0);
      load(mask, pk_min, pk_max, len_min, len_max);
      guard = 0;
      while ((exp_q.size() > 0 || pending()) && guard < 6000) begin
         step();
         guard++;
      end
      if (guard >= 6000) begin
         tests++;
         fails++;
         $display("FAIL phase_timeout: got %0d bytes outstanding required 0", exp_q.size());
         abort = 1'b1;
         return;
      end
      step();
      step();
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL busy_end: got %b required 0", busy);
      end
      tests++;
      if (acc_q.size() != 0) begin
         fails++;
         $display("FAIL accept_count: got %0d extra accepts required 0", acc_q.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      tests++;
      if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || cur_ch !== 4'd0 || bus.tx_data !== 8'd0 ||
          bus.req_ready !== '0 || bus.in_ready !== '0) begin
         fails++;
         $display("FAIL %s: got v=%b busy=%b ch=%0d d=%02h rr=%b ir=%b required all 0", tag,
                  bus.tx_valid, busy, cur_ch, bus.tx_data, bus.req_ready, bus.in_ready);
      end
   endtask

   initial begin
      bus.req_valid = '1;
      bus.req_len   = '0;
      bus.in_valid  = '1;
      bus.in_data   = '0;
      bus.tx_ready  = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         streaming[c] = 1'b0;
         sent[c]      = 0;
      end
      repeat (3) @(posedge tx_clk);
      #1;
      check_reset_outputs("reset_state");
      bus.req_valid = '0;
      bus.in_valid  = '0;
      rstn_async    = 1'b1;
      repeat (3) @(posedge tx_clk);
      #1;
      mon_en = 1'b1;

      phase(4'b0001, 1, 1, 3, 3, 0, 100, 0);
      phase(4'b1110, 1, 1, 1, 1, 0, 100, 0);
      phase(4'b0110, 2, 2, 1, 4, 0, 100, 0);
      phase(4'b1001, 1, 1, 256, 256, 0, 100, 0);
      phase(4'b0100, 1, 1, 12, 12, 0, 100, 1);
      phase(4'b1000, 1, 1, 8, 8, 50, 100, 0);
      for (int r = 0; r < 8; r++)
         phase(4'($urandom_range(15, 1)), 1, 3, 1, 24, int'($urandom_range(60, 0)),
               int'($urandom_range(100, 40)), int'($urandom_range(1, 0)));

      if (!abort) begin
         gap_pct   = 0;
         rdy_pct   = 100;
         bp_arm    = 0;
         exact_lat = 1'b1;
         load(4'b0100, 1, 1, 60, 60);
         for (int i = 0; i < 20; i++) step();
         tests++;
         if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_mid: got %b required 1", busy);
         end
         mon_en = 1'b0;
         #2 rstn_async = 1'b0;
         bus.req_valid = '1;
         #1;
         check_reset_outputs("reset_mid_packet");
         exp_q.delete();
         acc_q.delete();
         for (int c = 0; c < NCH; c++) begin
            rem_len[c].delete();
            pay[c].delete();
            streaming[c] = 1'b0;
         end
         m_last = NCH - 1;
         bus.req_valid = '0;
         repeat (3) @(posedge tx_clk);
         #1 rstn_async = 1'b1;
         repeat (3) @(posedge tx_clk);
         #1 mon_en = 1'b1;
         phase(4'b1111, 1, 1, 2, 5, 0, 100, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish within 900000 time units required finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
